// File: rtl/sd_cmd_engine_if.sv
// Controller-facing handshake and response bus of sd_cmd_engine.
// master = SD controller FSM, slave = command engine.
interface sd_cmd_engine_if;
  logic         cmd_start;
  logic         cmd_ready;
  logic [5:0]   cmd_index;
  logic [31:0]  cmd_arg;
  logic [1:0]   resp_type;
  logic         done;
  logic [135:0] resp_data;
  logic         timeout;
  logic         crc_err;
  logic         index_err;

  modport master (
    output cmd_start, cmd_index, cmd_arg, resp_type,
    input  cmd_ready, done, resp_data, timeout, crc_err, index_err
  );

  modport slave (
    input  cmd_start, cmd_index, cmd_arg, resp_type,
    output cmd_ready, done, resp_data, timeout, crc_err, index_err
  );
endinterface

// File: rtl/sd_cmd_engine.sv
// SD CMD-line engine: sends a 48-bit command with CRC7, then receives an R48/R136 response.
// Optional receive CRC7 checker built when SD_CMD_CRC_CHECK_EN is defined.
module sd_cmd_engine #(
  parameter int unsigned NCR_MAX = 64,
  parameter int unsigned NCC     = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            bit_en,
  sd_cmd_engine_if.slave  bus,
  output logic            cmd_o,
  output logic            cmd_oe,
  input  logic            cmd_i
);

  localparam int unsigned CMAX = (NCR_MAX > 136) ? ((NCR_MAX > NCC) ? NCR_MAX : NCC)
                                                 : ((NCC > 136) ? NCC : 136);
  localparam int unsigned CW   = $clog2(CMAX + 1);

  typedef enum logic [2:0] {IDLE, SEND, WAIT, RECV, GAP} state_t;

  state_t         state, state_next;
  logic [CW-1:0]  cnt;
  logic [39:0]    tx_sr;
  logic [6:0]     crc;
  logic [5:0]     idx_r;
  logic [1:0]     type_r;
  logic [135:0]   rx;
  logic           done_r, timeout_r, index_err_r;
  logic           ready, accept, tx_bit, last_rx;
  logic [135:0]   rx_next;

  function automatic logic [6:0] crc_step(input logic [6:0] c, input logic b);
    logic fb;
    fb = c[6] ^ b;
    return {c[5:0], 1'b0} ^ {3'b000, fb, 2'b00, fb};
  endfunction

  assign ready  = (state == IDLE) && !done_r;
  assign accept = bus.cmd_start && ready;

  always_comb begin
    state_next = state;
    tx_bit     = 1'b1;
    rx_next    = {rx[134:0], cmd_i};
    last_rx    = (cnt == ((type_r == 2'd2) ? CW'(135) : CW'(47)));
    if (cnt < CW'(40))
      tx_bit = tx_sr[39];
    else if (cnt < CW'(47))
      tx_bit = crc[6];
    case (state)
      IDLE: if (accept) state_next = SEND;
      SEND: if (bit_en && cnt == CW'(47)) state_next = (type_r == 2'd0) ? GAP : WAIT;
      WAIT: if (bit_en) begin
        if (!cmd_i)
          state_next = RECV;
        else if (cnt == CW'(NCR_MAX - 1))
          state_next = GAP;
      end
      RECV: if (bit_en && last_rx) state_next = GAP;
      GAP:  if (bit_en && cnt == CW'(NCC - 1)) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt         <= '0;
      tx_sr       <= '0;
      crc         <= '0;
      idx_r       <= '0;
      type_r      <= '0;
      rx          <= '0;
      done_r      <= 1'b0;
      timeout_r   <= 1'b0;
      index_err_r <= 1'b0;
      cmd_o       <= 1'b1;
      cmd_oe      <= 1'b0;
    end else begin
      done_r <= 1'b0;
      // Entering RECV already consumed the start bit, so the bit index starts at 1.
      if (state_next != state)
        cnt <= (state_next == RECV) ? CW'(1) : '0;
      else if (bit_en && state != IDLE)
        cnt <= cnt + 1'b1;
      if (bit_en) begin
        cmd_oe <= (state == SEND);
        cmd_o  <= (state == SEND) ? tx_bit : 1'b1;
      end
      case (state)
        IDLE: if (accept) begin
          tx_sr       <= {2'b01, bus.cmd_index, bus.cmd_arg};
          idx_r       <= bus.cmd_index;
          type_r      <= bus.resp_type;
          crc         <= '0;
          rx          <= '0;
          timeout_r   <= 1'b0;
          index_err_r <= 1'b0;
        end
        // Shifting the CRC out leaves it zero, ready to be reused by the receive checker.
        SEND: if (bit_en) begin
          if (cnt < CW'(40)) begin
            tx_sr <= {tx_sr[38:0], 1'b0};
            crc   <= crc_step(crc, tx_sr[39]);
          end else begin
            crc <= {crc[5:0], 1'b0};
          end
        end
        WAIT: if (bit_en) begin
          if (!cmd_i)
            rx <= rx_next;
          else if (cnt == CW'(NCR_MAX - 1))
            timeout_r <= 1'b1;
        end
        RECV: if (bit_en) begin
          rx <= rx_next;
`ifdef SD_CMD_CRC_CHECK_EN
          if ((type_r == 2'd1 && cnt < CW'(40)) ||
              (type_r == 2'd2 && cnt >= CW'(8) && cnt < CW'(128)))
            crc <= crc_step(crc, cmd_i);
`endif
          if (last_rx && type_r == 2'd1)
            index_err_r <= (rx_next[45:40] != idx_r);
        end
        GAP: if (bit_en && cnt == CW'(NCC - 1)) done_r <= 1'b1;
        default: ;
      endcase
    end
  end

`ifdef SD_CMD_CRC_CHECK_EN
  logic crc_err_r;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      crc_err_r <= 1'b0;
    else if (accept)
      crc_err_r <= 1'b0;
    else if (state == RECV && bit_en && last_rx && (type_r == 2'd1 || type_r == 2'd2))
      crc_err_r <= (crc != rx_next[7:1]);
  end

  assign bus.crc_err = crc_err_r;
`else
  assign bus.crc_err = 1'b0;
`endif

  assign bus.cmd_ready = ready;
  assign bus.done      = done_r;
  assign bus.resp_data = rx;
  assign bus.timeout   = timeout_r;
  assign bus.index_err = index_err_r;

endmodule

// File: tb/tb_sd_cmd_engine.sv
// Scoreboard bench for sd_cmd_engine: card model plus reference frames built from CRC7 rules.
module tb_sd_cmd_engine;
  localparam int unsigned NCR  = 64;
  localparam int unsigned GAPN = 8;

  logic clk = 1'b0;
  logic rst, bit_en, cmd_i, cmd_o, cmd_oe;
  sd_cmd_engine_if bus();

  sd_cmd_engine #(.NCR_MAX(NCR), .NCC(GAPN)) dut (
    .clk(clk), .rst(rst), .bit_en(bit_en), .bus(bus),
    .cmd_o(cmd_o), .cmd_oe(cmd_oe), .cmd_i(cmd_i)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [135:0] resp;
    logic         to, ce, ie;
    int unsigned  lat;
  } exp_t;

  exp_t        exp_q[$];
  logic [47:0] tx_q[$];
  int          checks = 0, errors = 0;
  int unsigned be_mode = 0, phase = 0, bitcnt = 0, acc_mark = 0;
  logic        last_be = 1'b0;
  logic [47:0] txf = '0;
  int unsigned txn = 0;

  task automatic chk(input string name, input logic [135:0] act, input logic [135:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Remainder of data * x^7 divided by x^7 + x^3 + 1, over the low n bits of data.
  function automatic logic [6:0] crc7(input logic [119:0] data, input int unsigned n);
    logic [6:0] c;
    logic       fb;
    c = '0;
    for (int unsigned i = 0; i < n; i++) begin
      fb = c[6] ^ data[n-1-i];
      c  = {c[5:0], 1'b0};
      if (fb) c = c ^ 7'h09;
    end
    return c;
  endfunction

  initial begin
    bit_en = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (be_mode)
        0: bit_en = 1'b1;
        1: begin phase = (phase + 1) % 4; bit_en = (phase == 0); end
        default: bit_en = 1'($urandom_range(0, 1));
      endcase
    end
  end

  always @(posedge clk) begin
    if (bit_en) bitcnt++;
    last_be <= bit_en;
  end

  task automatic wait_bit();
    do @(posedge clk); while (!bit_en);
    #1;
  endtask

  task automatic wait_ready();
    for (int unsigned i = 0; i < 8000; i++) begin
      if (bus.cmd_ready) return;
      @(posedge clk); #1;
    end
    checks++; errors++;
    $display("FAIL ready_wait: cmd_ready still 0 after 8000 cycles, required 1");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  endtask

  // beh: 0 good response, 1 one CRC bit flipped, 2 returned index = bad_idx, 3 card silent
  task automatic run_cmd(input logic [5:0] idx, input logic [31:0] arg, input logic [1:0] rt,
                         input int unsigned beh, input int unsigned d, input int unsigned flipk,
                         input logic [5:0] bad_idx, input logic [119:0] body,
                         input logic use_lit, input logic [47:0] lit);
    logic [39:0]  payload;
    logic [135:0] frame;
    logic [5:0]   ridx;
    int unsigned  len;
    exp_t         e;
    payload = {2'b01, idx, arg};
    tx_q.push_back(use_lit ? lit : {payload, crc7({80'd0, payload}, 40), 1'b1});
    e.resp = '0; e.to = 1'b0; e.ce = 1'b0; e.ie = 1'b0; e.lat = 48 + GAPN;
    len = 0; frame = '0;
    if (rt != 2'd0) begin
      if (beh == 3) begin
        e.to = 1'b1; e.lat = 48 + NCR + GAPN;
      end else begin
        if (rt == 2'd2) begin
          len   = 136;
          frame = {2'b00, 6'h3F, body, crc7(body, 120), 1'b1};
        end else begin
          ridx  = (beh == 2) ? bad_idx : idx;
          len   = 48;
          frame = {88'd0, 2'b00, ridx, arg, crc7({80'd0, 2'b00, ridx, arg}, 40), 1'b1};
          e.ie  = (rt == 2'd1) && (ridx != idx);
        end
        if (beh == 1) frame[1 + flipk] = ~frame[1 + flipk];
`ifdef SD_CMD_CRC_CHECK_EN
        e.ce = (beh == 1) && (rt != 2'd3);
`endif
        e.resp = frame;
        e.lat  = 48 + d + len + GAPN;
      end
    end
    exp_q.push_back(e);
    wait_ready();
    bus.cmd_index = idx; bus.cmd_arg = arg; bus.resp_type = rt; bus.cmd_start = 1'b1;
    @(posedge clk); #1;
    acc_mark = bitcnt;
    bus.cmd_start = 1'b0;
    bus.cmd_index = 6'($urandom); bus.cmd_arg = $urandom; bus.resp_type = 2'($urandom);
    repeat (48) wait_bit();
    if (rt != 2'd0 && beh != 3) begin
      repeat (d) wait_bit();
      for (int unsigned i = 0; i < len; i++) begin
        cmd_i = frame[len-1-i];
        wait_bit();
      end
      cmd_i = 1'b1;
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst && bus.done) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_done: got done=1, required no pending command");
      end else begin
        e = exp_q.pop_front();
        chk("resp_data", bus.resp_data, e.resp);
        chk("timeout", 136'(bus.timeout), 136'(e.to));
        chk("crc_err", 136'(bus.crc_err), 136'(e.ce));
        chk("index_err", 136'(bus.index_err), 136'(e.ie));
        chk("done_latency", 136'(bitcnt - acc_mark), 136'(e.lat));
        chk("ready_with_done", 136'(bus.cmd_ready), 136'(0));
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) txn = 0;
    else if (last_be) begin
      if (cmd_oe) begin
        txf = {txf[46:0], cmd_o};
        txn++;
      end else if (txn != 0) begin
        chk("tx_bits", 136'(txn), 136'(48));
        if (tx_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL tx_unexpected: frame %0h sent, required nothing pending", txf);
        end else begin
          chk("tx_frame", 136'(txf), 136'(tx_q.pop_front()));
        end
        txn = 0;
      end
    end
  end

  initial begin
    #900000;
    errors++;
    $display("FAIL watchdog: simulation exceeded 90000 cycles");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [119:0] cid;
    logic [5:0]   idx;
    logic [1:0]   rt;
    rst = 1'b0; cmd_i = 1'b1;
    bus.cmd_start = 1'b0; bus.cmd_index = '0; bus.cmd_arg = '0; bus.resp_type = '0;
    repeat (3) @(posedge clk); #1;
    chk("rst_ready", 136'(bus.cmd_ready), 136'(1));
    chk("rst_oe", 136'(cmd_oe), 136'(0));
    chk("rst_cmd_o", 136'(cmd_o), 136'(1));
    chk("rst_done", 136'(bus.done), 136'(0));
    chk("rst_flags", 136'({bus.timeout, bus.crc_err, bus.index_err}), 136'(0));
    chk("rst_resp", bus.resp_data, 136'(0));
    rst = 1'b1;
    @(posedge clk); #1;

    run_cmd(6'd0, 32'h0, 2'd0, 0, 0, 0, 6'd0, '0, 1'b1, 48'h400000000095);
    run_cmd(6'd8, 32'h1AA, 2'd1, 0, 5, 0, 6'd0, '0, 1'b1, 48'h48000001AA87);
    run_cmd(6'd8, 32'h1AA, 2'd1, 1, 5, 3, 6'd0, '0, 1'b1, 48'h48000001AA87);
    run_cmd(6'd8, 32'h1AA, 2'd1, 2, 5, 0, 6'h37, '0, 1'b1, 48'h48000001AA87);
    cid = 120'({$urandom, $urandom, $urandom, $urandom});
    run_cmd(6'd2, 32'h0, 2'd2, 0, 3, 0, 6'd0, cid, 1'b0, '0);
    be_mode = 1;
    run_cmd(6'd2, 32'h0, 2'd2, 0, 3, 0, 6'd0, cid, 1'b0, '0);
    run_cmd(6'd2, 32'h0, 2'd2, 1, 7, 6, 6'd0, cid, 1'b0, '0);
    be_mode = 0;
    run_cmd(6'd17, 32'h1234, 2'd1, 3, 0, 0, 6'd0, '0, 1'b0, '0);
    run_cmd(6'd41, 32'h00FF8000, 2'd3, 2, 0, 0, 6'h3F, '0, 1'b0, '0);
    run_cmd(6'd41, 32'h00FF8000, 2'd3, 1, NCR - 1, 2, 6'd0, '0, 1'b0, '0);

    // Reset in the middle of a command: pad released at once, next command clean.
    wait_ready();
    bus.cmd_index = 6'd0; bus.cmd_arg = 32'h0; bus.resp_type = 2'd0; bus.cmd_start = 1'b1;
    @(posedge clk); #1;
    bus.cmd_start = 1'b0;
    repeat (21) wait_bit();
    chk("oe_before_reset", 136'(cmd_oe), 136'(1));
    rst = 1'b0; #1;
    chk("oe_async_reset", 136'(cmd_oe), 136'(0));
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("ready_after_reset", 136'(bus.cmd_ready), 136'(1));
    run_cmd(6'd0, 32'h0, 2'd0, 0, 0, 0, 6'd0, '0, 1'b1, 48'h400000000095);

    for (int unsigned t = 0; t < 30; t++) begin
      be_mode = $urandom_range(0, 2);
      idx = 6'($urandom);
      rt  = 2'($urandom_range(0, 3));
      cid = 120'({$urandom, $urandom, $urandom, $urandom});
      run_cmd(idx, $urandom, rt, $urandom_range(0, 3), $urandom_range(0, NCR - 1),
              $urandom_range(0, 6), idx ^ 6'($urandom_range(1, 63)), cid, 1'b0, '0);
    end

    be_mode = 0;
    wait_ready();
    repeat (2) @(posedge clk); #1;
    chk("pending_resp", 136'(exp_q.size()), 136'(0));
    chk("pending_tx", 136'(tx_q.size()), 136'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
